// File: rtl/game_status_scanner.sv
// game_status_scanner: walks the active level's defuse/mine arrays one field per clock and reports defused count, sticky win/lose; `SCAN_EARLY_ABORT_EN ends a scan at the first defused mine
module game_status_scanner #(
  parameter int COUNT_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          level,
  input  logic                new_game,
  input  logic                start,
  input  logic [7:0][7:0]     mine_arr_easy,
  input  logic [9:0][9:0]     mine_arr_medium,
  input  logic [15:0][15:0]   mine_arr_hard,
  input  logic [7:0][7:0]     defuse_arr_easy,
  input  logic [9:0][9:0]     defuse_arr_medium,
  input  logic [15:0][15:0]   defuse_arr_hard,
  output logic                busy,
  output logic                scan_done,
  output logic [COUNT_W-1:0]  defused_count,
  output logic                win,
  output logic                lose
);
  typedef enum logic [1:0] {IDLE, SCAN, EVAL} state_t;
  state_t state_q, state_d;
  logic [1:0] lvl_q, lvl_d;
  logic [3:0] x_q, x_d, y_q, y_d, last;
  logic [COUNT_W-1:0] dc_q, dc_d, mc_q, mc_d, cnt_q, cnt_d, area;
  logic hit_q, hit_d, win_q, win_d, lose_q, lose_d, done_q, done_d;
  logic mine_b, def_b, hit_now;
  // current field of the sampled level and that level's geometry
  always_comb begin
    last = lvl_q == 2'd1 ? 4'd7 : lvl_q == 2'd2 ? 4'd9 : 4'd15;
    area = lvl_q == 2'd1 ? COUNT_W'(64) : lvl_q == 2'd2 ? COUNT_W'(100) : COUNT_W'(256);
    mine_b = lvl_q == 2'd1 ? mine_arr_easy[y_q[2:0]][x_q[2:0]] :
             lvl_q == 2'd2 ? mine_arr_medium[y_q][x_q] : mine_arr_hard[y_q][x_q];
    def_b = lvl_q == 2'd1 ? defuse_arr_easy[y_q[2:0]][x_q[2:0]] :
            lvl_q == 2'd2 ? defuse_arr_medium[y_q][x_q] : defuse_arr_hard[y_q][x_q];
    hit_now = mine_b & def_b;
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lvl_q <= '0;
      x_q <= '0;
      y_q <= '0;
      dc_q <= '0;
      mc_q <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
      win_q <= 1'b0;
      lose_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q <= lvl_d;
      x_q <= x_d;
      y_q <= y_d;
      dc_q <= dc_d;
      mc_q <= mc_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      win_q <= win_d;
      lose_q <= lose_d;
      done_q <= done_d;
    end
  end
  // next state: new_game aborts and clears, IDLE accepts start, SCAN walks the board, EVAL publishes
  always_comb begin
    state_d = state_q;
    lvl_d = lvl_q;
    x_d = x_q;
    y_d = y_q;
    dc_d = dc_q;
    mc_d = mc_q;
    hit_d = hit_q;
    cnt_d = cnt_q;
    win_d = win_q;
    lose_d = lose_q;
    done_d = 1'b0;
    if (new_game) begin
      state_d = IDLE;
      cnt_d = '0;
      win_d = 1'b0;
      lose_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (start && level != 2'd0 && !win_q && !lose_q) begin
        state_d = SCAN;
        lvl_d = level;
        x_d = '0;
        y_d = '0;
        dc_d = '0;
        mc_d = '0;
        hit_d = 1'b0;
      end
    end else if (state_q == SCAN) begin
      if (level != lvl_q) begin
        state_d = IDLE;
      end else begin
        dc_d = dc_q + COUNT_W'(def_b);
        mc_d = mc_q + COUNT_W'(mine_b);
        hit_d = hit_q | hit_now;
        x_d = x_q == last ? 4'd0 : x_q + 4'd1;
        y_d = x_q == last ? y_q + 4'd1 : y_q;
`ifdef SCAN_EARLY_ABORT_EN
        state_d = (x_q == last && y_q == last) || hit_now ? EVAL : SCAN;
`else
        state_d = x_q == last && y_q == last ? EVAL : SCAN;
`endif
      end
    end else begin
      state_d = IDLE;
      cnt_d = dc_q;
      done_d = 1'b1;
      lose_d = lose_q | hit_q;
      win_d = win_q | (!hit_q && mc_q != '0 && dc_q == area - mc_q);
    end
  end
  // outputs
  always_comb begin
    busy = state_q == SCAN;
    scan_done = done_q;
    defused_count = cnt_q;
    win = win_q;
    lose = lose_q;
  end
endmodule

// File: tb/tb_game_status_scanner.sv
// tb_game_status_scanner: randomized and directed checks of game_status_scanner against a raster-order board model
module tb_game_status_scanner;
  localparam int COUNT_W = 9;
`ifdef SCAN_EARLY_ABORT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, new_game = 1'b0, start = 1'b0;
  logic [1:0] lvl = 2'd0;
  logic [7:0][7:0] me = '0, de = '0;
  logic [9:0][9:0] mm = '0, dm = '0;
  logic [15:0][15:0] mh = '0, dh = '0;
  logic busy, scan_done, win, lose;
  logic [COUNT_W-1:0] defused_count;
  int n_checks = 0, n_fail = 0, ecnt = 0;
  bit ew = 1'b0, el = 1'b0;

  always #5 clk = ~clk;

  game_status_scanner #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst), .level(lvl), .new_game(new_game), .start(start),
    .mine_arr_easy(me), .mine_arr_medium(mm), .mine_arr_hard(mh),
    .defuse_arr_easy(de), .defuse_arr_medium(dm), .defuse_arr_hard(dh),
    .busy(busy), .scan_done(scan_done), .defused_count(defused_count),
    .win(win), .lose(lose)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int side(input int l);
    return l == 1 ? 8 : l == 2 ? 10 : 16;
  endfunction

  task automatic set_field(input int l, input int y, input int x, input bit m, input bit d);
    if (l == 1) begin me[y][x] = m; de[y][x] = d; end
    else if (l == 2) begin mm[y][x] = m; dm[y][x] = d; end
    else begin mh[y][x] = m; dh[y][x] = d; end
  endtask

  function automatic bit get_m(input int l, input int y, input int x);
    return l == 1 ? me[y][x] : l == 2 ? mm[y][x] : mh[y][x];
  endfunction

  function automatic bit get_d(input int l, input int y, input int x);
    return l == 1 ? de[y][x] : l == 2 ? dm[y][x] : dh[y][x];
  endfunction

  task automatic clear_all();
    me = '0; de = '0; mm = '0; dm = '0; mh = '0; dh = '0;
  endtask

  task automatic model(input int l, output int scanned, output int cnt, output int mines, output bit hit);
    int n;
    bit m, d;
    n = side(l);
    scanned = 0; cnt = 0; mines = 0; hit = 1'b0;
    for (int i = 0; i < n * n; i++) begin
      m = get_m(l, i / n, i % n);
      d = get_d(l, i / n, i % n);
      scanned++;
      cnt += int'(d);
      mines += int'(m);
      if (m && d) begin
        hit = 1'b1;
        if (EARLY) break;
      end
    end
  endtask

  task automatic fill(input int l, input int mode);
    int n;
    bit m, d;
    n = side(l);
    for (int y = 0; y < n; y++)
      for (int x = 0; x < n; x++) begin
        m = $urandom_range(0, 99) < 12;
        d = 1'b0;
        case (mode)
          0: d = !m;
          1: d = 1'($urandom_range(0, 1));
          2: begin m = 1'b0; d = 1'b1; end
          default: d = !m && $urandom_range(0, 9) != 0;
        endcase
        set_field(l, y, x, m, d);
      end
  endtask

  task automatic check_outputs(input string tag);
    check($sformatf("%s_cnt", tag), 32'(defused_count), 32'(ecnt));
    check($sformatf("%s_win", tag), 32'(win), 32'(ew));
    check($sformatf("%s_lose", tag), 32'(lose), 32'(el));
  endtask

  task automatic new_game_pulse(input string tag);
    new_game = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    start = 1'b0;
    ecnt = 0; ew = 1'b0; el = 1'b0;
    check_outputs(tag);
    check($sformatf("%s_busy", tag), 32'(busy), 0);
  endtask

  task automatic run_scan(input string tag, input bit extra);
    int scanned, cnt, mines, cyc, bc, n;
    bit hit, done, wn;
    if (lvl == 2'd0 || ew || el) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bc = 0;
      repeat (5) begin
        bc += int'(busy) + int'(scan_done);
        @(posedge clk); #1;
      end
      check($sformatf("%s_ignored", tag), 32'(bc), 0);
      check_outputs(tag);
      return;
    end
    model(int'(lvl), scanned, cnt, mines, hit);
    n = side(int'(lvl));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; bc = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      bc += int'(busy);
      @(posedge clk); #1;
      cyc++;
      if (extra && cyc == 10) start = 1'b1;
      if (extra && cyc == 11) start = 1'b0;
      done = scan_done;
    end
    wn = !hit && mines != 0 && cnt == n * n - mines;
    ecnt = cnt;
    el = el | hit;
    ew = ew | wn;
    check($sformatf("%s_latency", tag), 32'(cyc), 32'(scanned + 1));
    check($sformatf("%s_busy_cycles", tag), 32'(bc), 32'(scanned));
    check_outputs(tag);
    @(posedge clk); #1;
    check($sformatf("%s_done_pulse", tag), 32'(scan_done), 0);
    check($sformatf("%s_idle_after", tag), 32'(busy), 0);
  endtask

  initial begin
    int bc, l;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(scan_done), 0);
    check_outputs("rst");
    rst = 1'b1;

    clear_all();
    lvl = 2'd1;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        set_field(1, y, x, (y == 0 && x == 0) || (y == 7 && x == 7), !((y == 0 && x == 0) || (y == 7 && x == 7)));
    run_scan("easy_win", 1'b0);
    check("easy_win_cnt62", 32'(defused_count), 62);
    check("easy_win_flag", 32'(win), 1);
    run_scan("easy_after_win", 1'b0);
    new_game_pulse("ng_after_win");
    run_scan("easy_again", 1'b0);
    new_game_pulse("ng_easy");

    clear_all();
    lvl = 2'd2;
    set_field(2, 3, 4, 1'b1, 1'b1);
    run_scan("med_hit", 1'b0);
    check("med_hit_lose", 32'(lose), 1);
    new_game_pulse("ng_med");

    clear_all();
    lvl = 2'd3;
    begin
      int mines, defs;
      mines = 0; defs = 0;
      for (int i = 0; i < 256; i++)
        if (i % 6 == 0 && mines < 40) begin set_field(3, i / 16, i % 16, 1'b1, 1'b0); mines++; end
        else if (defs < 100) begin set_field(3, i / 16, i % 16, 1'b0, 1'b1); defs++; end
    end
    run_scan("hard", 1'b1);
    check("hard_cnt100", 32'(defused_count), 100);

    clear_all();
    lvl = 2'd1;
    for (int i = 0; i < 20; i++) set_field(1, i / 8, i % 8, 1'b0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    check("abort_busy_before", 32'(busy), 1);
    lvl = 2'd2;
    @(posedge clk); #1;
    check("abort_busy_drop", 32'(busy), 0);
    bc = 0;
    repeat (120) begin
      bc += int'(scan_done) + int'(busy);
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(bc), 0);
    check_outputs("abort");

    for (int it = 0; it < 10; it++) begin
      l = $urandom_range(1, 3);
      lvl = 2'(l);
      clear_all();
      fill(l, $urandom_range(0, 3));
      if (ew || el || $urandom_range(0, 1) == 1) new_game_pulse($sformatf("ng_rnd%0d", it));
      run_scan($sformatf("rnd%0d_l%0d", it, l), 1'b0);
    end

    if (ew || el) new_game_pulse("ng_pre_rst");
    lvl = 2'd3;
    clear_all();
    fill(3, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ecnt = 0; ew = 1'b0; el = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(scan_done), 0);
    check_outputs("midrst");
    lvl = 2'd0;
    run_scan("lvl0", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/game_status_scanner.md
Name: game_status_scanner

Overview:
- Downstream consumer of the defuse-array generator.
- On request, walks the active level's defuse array and mine array one field per clock.
- Counts defused fields and detects a defused mine (loss) or a fully cleared board (win).
- Feeds the end-of-game overlay and game FSM with sticky win/lose flags and a defused-field count.

Parameters:
- COUNT_W, 9, width of the defused_count and internal mine counter; must hold 256.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- level  input  2  1=easy 8x8, 2=medium 10x10, 3=hard 16x16, 0=no game
- new_game  input  1  one-cycle pulse; clears sticky flags
- start  input  1  one-cycle scan request
- mine_arr_easy  input  8x8  '1 = mine, indexed [y][x]
- mine_arr_medium  input  10x10  same as easy
- mine_arr_hard  input  16x16  same as easy
- defuse_arr_easy  input  8x8  '1 = defused field, indexed [y][x]
- defuse_arr_medium  input  10x10  same as easy
- defuse_arr_hard  input  16x16  same as easy
- busy  output  1  high while a scan is in progress
- scan_done  output  1  one-cycle pulse when results update
- defused_count  output  COUNT_W  defused fields found by the last completed scan
- win  output  1  sticky: board cleared
- lose  output  1  sticky: a mine field was defused

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; all outputs 0; internal counters, indices and the hit flag cleared.
- N is 8, 10 or 16 per level. Level is sampled when start is accepted.
- States:
  - IDLE: start==1 && level!=0 && !win && !lose → SCAN with x=y=0, counters cleared, busy=1.
  - IDLE: start with level==0, or start with win or lose set → ignored.
  - SCAN: each cycle examines field [y][x] of the sampled level's arrays.
    - defuse bit → defused counter +1.
    - mine bit → mine counter +1.
    - defuse && mine → hit flag set.
    - x increments; at x==N-1, x wraps to 0 and y increments.
    - After field [N-1][N-1], go to EVAL.
  - EVAL (one cycle): load defused_count; pulse scan_done; busy=0.
    - lose <= lose | hit.
    - win <= win | (!hit && mine_cnt!=0 && defused_cnt == N*N - mine_cnt).
    - Return to IDLE.
- Latency: start accepted at edge k → fields examined at edges k+1..k+N*N; scan_done high in the cycle after edge k+N*N+1.
  - Easy: 64 scan cycles, scan_done at start+65.
  - Medium: start+101.
  - Hard: start+257.
- start while busy: ignored; no queuing.
- Level changes mid-scan: abort to IDLE, busy=0, no scan_done, outputs unchanged.
- new_game: clears win, lose and defused_count next edge; aborts any scan to IDLE without scan_done.
  - Overrides start in the same cycle.
  - Lower priority than rst.
- Arrays are read live each cycle; changes during a scan are taken as seen per field, with no snapshot.
- win and lose never both set by one EVAL: lose takes precedence, since win requires !hit.
- Arithmetic: N*N-mine_cnt computed in COUNT_W bits; mine_cnt never exceeds N*N.

Optional Feature:
- Macro SCAN_EARLY_ABORT_EN.
- Defined: the first cycle in SCAN where defuse && mine is true goes straight to EVAL next cycle.
  - Effect: lose is set and scan_done pulses early.
  - defused_count reports fields counted so far, including the hit field.
- Undefined: the full N*N scan always runs.

Test Plan:
- Easy, mines at [0][0] and [7][7], all other 62 fields defused; start → scan_done 65 cycles later, defused_count=62, win=1, lose=0, busy high for 64 cycles.
- Medium, mine at [3][4] and defuse at [3][4]; start → lose=1, win=0, defused_count=1; without the macro scan_done at start+101; with SCAN_EARLY_ABORT_EN scan_done at start+36.
- Hard, 40 mines, 100 defused non-mine fields → scan_done at start+257, defused_count=100, win=0, lose=0; a second start during busy has no effect.
- Easy scan in progress, level changed to 2 at cycle 20 → busy drops next edge, no scan_done, defused_count retains previous value.
- After win=1, start → ignored; new_game pulse → win=0, defused_count=0; new start then runs normally.
- rst low mid-scan for one edge → all outputs 0, state IDLE; start with level=0 → busy stays 0.
